// File: rtl/rotation_angle_ctrl_if.sv
// ----------------------------------------------------------------------------
// rotation_angle_ctrl_if
// Bundles the rotation angle controller's switch inputs, frame sync,
// sine/cosine LUT address/data and the committed coefficient outputs.
//   slave  : controller side (rotation_angle_ctrl)
//   master : surroundings (pixel mapper, switches, sin/cos LUT ROMs)
// Ports carried:
//   iFRAME_SYNC  one-cycle pulse on the last pixel of a frame
//   iAUTO        1 = auto-rotate, 0 = manual angle
//   iDIR         auto direction, 0 = increasing, 1 = decreasing
//   iTHETA_SET   manual angle index / auto step size
//   iRATE        auto frames per step (0 behaves as 1)
//   oLUT_ADDR    sin/cos LUT address
//   iSIN, iCOS   signed Q1.7 LUT data
//   oSIN, oCOS   committed signed Q1.7 coefficients
//   oANGLE       angle index matching oSIN/oCOS
//   oUPDATE      one-cycle pulse when coefficients are committed
//   oBUSY        controller is sequencing a frame update
// ----------------------------------------------------------------------------
interface rotation_angle_ctrl_if #(
  parameter int RATE_W = 8
);
  logic                    iFRAME_SYNC;
  logic                    iAUTO;
  logic                    iDIR;
  logic        [6:0]       iTHETA_SET;
  logic        [RATE_W-1:0] iRATE;
  logic        [6:0]       oLUT_ADDR;
  logic signed [7:0]       iSIN;
  logic signed [7:0]       iCOS;
  logic signed [7:0]       oSIN;
  logic signed [7:0]       oCOS;
  logic        [6:0]       oANGLE;
  logic                    oUPDATE;
  logic                    oBUSY;

  modport slave (
    input  iFRAME_SYNC, iAUTO, iDIR, iTHETA_SET, iRATE, iSIN, iCOS,
    output oLUT_ADDR, oSIN, oCOS, oANGLE, oUPDATE, oBUSY
  );

  modport master (
    output iFRAME_SYNC, iAUTO, iDIR, iTHETA_SET, iRATE, iSIN, iCOS,
    input  oLUT_ADDR, oSIN, oCOS, oANGLE, oUPDATE, oBUSY
  );
endinterface

// File: rtl/rotation_angle_ctrl.sv
// ----------------------------------------------------------------------------
// rotation_angle_ctrl
// Frame-synchronous sequencer for the rotation datapath. At each frame sync
// it samples the switches, computes the next angle index (manual absolute
// angle or auto step counted in frames), drives the shared sin/cos LUT
// address, waits out the LUT latency and commits the LUT data into
// coefficient registers that stay stable for the whole next frame.
// Ports:
//   CLK      system clock
//   RESET_N  asynchronous active-low reset
//   bus      rotation_angle_ctrl_if.slave (switches, frame sync, LUT
//            address/data, committed coefficients, update/busy flags)
// ----------------------------------------------------------------------------
module rotation_angle_ctrl #(
  parameter int ANGLE_STEPS = 71,
  parameter int LUT_LATENCY = 2,
  parameter int RATE_W      = 8
) (
  input logic                  CLK,
  input logic                  RESET_N,
  rotation_angle_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FETCH  = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  localparam logic [7:0] STEPS8    = 8'(ANGLE_STEPS);
  localparam logic [2:0] WAIT_LAST = 3'(LUT_LATENCY - 1);

  // Single conditional subtraction is enough because ANGLE_STEPS >= 64
  // and the index is only 7 bits wide.
  function automatic logic [6:0] reduce_theta(input logic [6:0] theta);
    if ({1'b0, theta} >= STEPS8)
      return 7'({1'b0, theta} - STEPS8);
    return theta;
  endfunction

  // Modular step of the angle index; both operands are already < ANGLE_STEPS.
  function automatic logic [6:0] step_angle(input logic [6:0] angle,
                                            input logic [6:0] t,
                                            input logic       dir);
    logic [7:0] res;
    if (!dir) begin
      res = {1'b0, angle} + {1'b0, t};
      if (res >= STEPS8)
        res = res - STEPS8;
    end else if (angle >= t) begin
      res = {1'b0, angle} - {1'b0, t};
    end else begin
      res = {1'b0, angle} + STEPS8 - {1'b0, t};
    end
    return res[6:0];
  endfunction

  logic [1:0]        state;
  logic [6:0]        addr_q;
  logic [6:0]        angle_q;
  logic signed [7:0] sin_q;
  logic signed [7:0] cos_q;
  logic [RATE_W-1:0] frame_cnt;
  logic [2:0]        wait_cnt;

  logic              auto_p0;
  logic              dir_p0;
  logic [6:0]        theta_p0;
  logic [RATE_W-1:0] rate_p0;

  logic [6:0]        theta_red;
  logic [RATE_W:0]   cnt_inc;
  logic [RATE_W:0]   rate_eff;
  logic              step_now;

  // ---- sync stage: switch snapshot taken only on an accepted frame sync ----
  always_ff @(posedge CLK) begin
    if (state == IDLE && bus.iFRAME_SYNC) begin
      auto_p0  <= bus.iAUTO;
      dir_p0   <= bus.iDIR;
      theta_p0 <= bus.iTHETA_SET;
      rate_p0  <= bus.iRATE;
    end
  end

  // ---- calc stage: next-angle decision from the snapshot ----
  always_comb begin
    theta_red = reduce_theta(theta_p0);
    cnt_inc   = {1'b0, frame_cnt} + (RATE_W + 1)'(1);
    rate_eff  = (rate_p0 == '0) ? (RATE_W + 1)'(1) : {1'b0, rate_p0};
    // >= rather than == so a rate lowered below the running count still steps
    step_now  = (cnt_inc >= rate_eff);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      addr_q    <= '0;
      angle_q   <= '0;
      sin_q     <= 8'sh00;
      cos_q     <= 8'sh7F;
      frame_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iFRAME_SYNC)
            state <= CALC;
        end
        CALC: begin
          if (!auto_p0) begin
            addr_q    <= theta_red;
            frame_cnt <= '0;
          end else if (step_now) begin
            addr_q    <= step_angle(angle_q, theta_red, dir_p0);
            frame_cnt <= '0;
          end else begin
            addr_q    <= angle_q;
            frame_cnt <= cnt_inc[RATE_W-1:0];
          end
          wait_cnt <= '0;
          state    <= FETCH;
        end
        // ---- fetch stage: address held while the LUT pipeline fills ----
        FETCH: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= COMMIT;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        // ---- commit stage: coefficients become visible next cycle ----
        COMMIT: begin
          sin_q   <= bus.iSIN;
          cos_q   <= bus.iCOS;
          angle_q <= addr_q;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oLUT_ADDR = addr_q;
  assign bus.oSIN      = sin_q;
  assign bus.oCOS      = cos_q;
  assign bus.oANGLE    = angle_q;
  assign bus.oUPDATE   = (state == COMMIT);
  assign bus.oBUSY     = (state != IDLE);

endmodule

// File: tb/tb_rotation_angle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rotation_angle_ctrl
// Self-checking bench for rotation_angle_ctrl: directed vector table, hand
// sequences for sync-while-busy, reset mid-fetch and mid-frame switch
// changes, then randomized frames against a modular-arithmetic angle model.
// ----------------------------------------------------------------------------
module tb_rotation_angle_ctrl;
  localparam int ANGLE_STEPS = 71;
  localparam int LUT_LATENCY = 2;
  localparam int RATE_W      = 8;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  rotation_angle_ctrl_if #(.RATE_W(RATE_W)) bus ();

  rotation_angle_ctrl #(
    .ANGLE_STEPS(ANGLE_STEPS),
    .LUT_LATENCY(LUT_LATENCY),
    .RATE_W     (RATE_W)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  // Behavioural sin/cos ROM contents: distinct per address, non-trivial at 0.
  function automatic logic signed [7:0] lut_sin(input int a);
    return 8'(a * 3 - 100);
  endfunction
  function automatic logic signed [7:0] lut_cos(input int a);
    return 8'(90 - a * 5);
  endfunction

  logic signed [7:0] sin_pipe [LUT_LATENCY];
  logic signed [7:0] cos_pipe [LUT_LATENCY];
  always @(posedge CLK) begin
    sin_pipe[0] <= lut_sin(int'(bus.oLUT_ADDR));
    cos_pipe[0] <= lut_cos(int'(bus.oLUT_ADDR));
    for (int i = 1; i < LUT_LATENCY; i++) begin
      sin_pipe[i] <= sin_pipe[i-1];
      cos_pipe[i] <= cos_pipe[i-1];
    end
  end
  assign bus.iSIN = sin_pipe[LUT_LATENCY-1];
  assign bus.iCOS = cos_pipe[LUT_LATENCY-1];

  int checks   = 0;
  int failures = 0;
  int m_angle  = 0;
  int m_cnt    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: angle is a residue mod ANGLE_STEPS, rate counted in frames.
  task automatic model_sync(input logic a, input logic d, input logic [6:0] th,
                            input logic [7:0] rt);
    int t, r;
    t = int'(th) % ANGLE_STEPS;
    if (!a) begin
      m_angle = t;
      m_cnt   = 0;
    end else begin
      m_cnt++;
      r = (rt == 0) ? 1 : int'(rt);
      if (m_cnt >= r) begin
        m_cnt = 0;
        if (d) m_angle = (m_angle - t + ANGLE_STEPS) % ANGLE_STEPS;
        else   m_angle = (m_angle + t) % ANGLE_STEPS;
      end
    end
  endtask

  task automatic scramble();
    bus.iAUTO      = 1'($urandom);
    bus.iDIR       = 1'($urandom);
    bus.iTHETA_SET = 7'($urandom);
    bus.iRATE      = 8'($urandom);
  endtask

  // One frame: sync at cycle N, optional extra sync while busy at offset
  // extra_k (1..4), switches scrambled after the sync, then full checks.
  task automatic run_frame(input logic a, input logic d, input logic [6:0] th,
                           input logic [7:0] rt, input int extra_k);
    int lat, pulses, prev, addr2, busy1;
    prev = m_angle;
    @(negedge CLK);
    bus.iAUTO = a; bus.iDIR = d; bus.iTHETA_SET = th; bus.iRATE = rt;
    bus.iFRAME_SYNC = 1'b1;
    model_sync(a, d, th, rt);
    lat = -1; pulses = 0; addr2 = -1; busy1 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      bus.iFRAME_SYNC = (k == extra_k);
      if (k == 1) begin
        scramble();
        busy1 = int'(bus.oBUSY);
      end
      if (k == 2) addr2 = int'(bus.oLUT_ADDR);
      if (k == 3) check("angle_stable_before_commit", int'(bus.oANGLE), prev);
      if (bus.oUPDATE) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
    check("busy_after_sync", busy1, 1);
    check("update_latency", lat, 2 + LUT_LATENCY);
    check("update_pulses", pulses, 1);
    check("lut_addr", addr2, m_angle);
    check("angle", int'(bus.oANGLE), m_angle);
    check("sin", int'(bus.oSIN), int'(lut_sin(m_angle)));
    check("cos", int'(bus.oCOS), int'(lut_cos(m_angle)));
    check("busy_idle", int'(bus.oBUSY), 0);
  endtask

  typedef struct {
    logic       a;
    logic       d;
    logic [6:0] th;
    logic [7:0] rt;
    int         exp;
  } vec_t;

  vec_t vt [22];

  initial begin
    int upd_seen, busy_seen, chg;
    logic [6:0] ang0;
    logic signed [7:0] s0, c0;

    vt[0]  = '{1'b0, 1'b0, 7'd10,  8'd0, 10};
    vt[1]  = '{1'b0, 1'b0, 7'd100, 8'd0, 29};
    vt[2]  = '{1'b0, 1'b0, 7'd60,  8'd0, 60};
    vt[3]  = '{1'b1, 1'b0, 7'd30,  8'd3, 60};
    vt[4]  = '{1'b1, 1'b0, 7'd30,  8'd3, 60};
    vt[5]  = '{1'b1, 1'b0, 7'd30,  8'd3, 19};
    vt[6]  = '{1'b1, 1'b0, 7'd30,  8'd3, 19};
    vt[7]  = '{1'b1, 1'b0, 7'd30,  8'd3, 19};
    vt[8]  = '{1'b1, 1'b0, 7'd30,  8'd3, 49};
    vt[9]  = '{1'b0, 1'b0, 7'd2,   8'd0, 2};
    vt[10] = '{1'b1, 1'b1, 7'd5,   8'd0, 68};
    vt[11] = '{1'b1, 1'b1, 7'd5,   8'd0, 63};
    vt[12] = '{1'b1, 1'b1, 7'd76,  8'd1, 58};
    vt[13] = '{1'b0, 1'b0, 7'd127, 8'd0, 56};
    vt[14] = '{1'b0, 1'b0, 7'd70,  8'd0, 70};
    vt[15] = '{1'b1, 1'b0, 7'd1,   8'd1, 0};
    vt[16] = '{1'b1, 1'b1, 7'd70,  8'd1, 1};
    vt[17] = '{1'b1, 1'b0, 7'd71,  8'd1, 1};
    vt[18] = '{1'b1, 1'b0, 7'd10,  8'd5, 1};
    vt[19] = '{1'b1, 1'b0, 7'd10,  8'd5, 1};
    vt[20] = '{1'b1, 1'b0, 7'd10,  8'd1, 11};
    vt[21] = '{1'b1, 1'b0, 7'd10,  8'd2, 11};

    RESET_N = 1'b0;
    bus.iFRAME_SYNC = 1'b0;
    bus.iAUTO = 1'b0; bus.iDIR = 1'b0; bus.iTHETA_SET = '0; bus.iRATE = '0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;

    // Reset state held with no sync
    upd_seen = 0; busy_seen = 0;
    repeat (10) begin
      @(negedge CLK);
      scramble();
      if (bus.oUPDATE) upd_seen++;
      if (bus.oBUSY) busy_seen++;
    end
    check("rst_sin", int'(bus.oSIN), 0);
    check("rst_cos", int'(bus.oCOS), 127);
    check("rst_angle", int'(bus.oANGLE), 0);
    check("rst_lut_addr", int'(bus.oLUT_ADDR), 0);
    check("rst_update_seen", upd_seen, 0);
    check("rst_busy_seen", busy_seen, 0);

    // Directed vector table
    for (int i = 0; i < 22; i++) begin
      run_frame(vt[i].a, vt[i].d, vt[i].th, vt[i].rt, 0);
      check($sformatf("table_angle[%0d]", i), int'(bus.oANGLE), vt[i].exp);
    end

    // Sync while busy is neither queued nor counted
    run_frame(1'b0, 1'b0, 7'd0, 8'd0, 0);
    run_frame(1'b1, 1'b0, 7'd7, 8'd2, 2);
    check("busy_sync_not_counted", int'(bus.oANGLE), 0);
    run_frame(1'b1, 1'b0, 7'd7, 8'd2, 3);
    check("busy_sync_second_frame", int'(bus.oANGLE), 7);

    // Reset during FETCH discards the partial fetch immediately
    @(negedge CLK);
    bus.iAUTO = 1'b0; bus.iTHETA_SET = 7'd40; bus.iFRAME_SYNC = 1'b1;
    @(negedge CLK);
    bus.iFRAME_SYNC = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("midrst_sin", int'(bus.oSIN), 0);
    check("midrst_cos", int'(bus.oCOS), 127);
    check("midrst_angle", int'(bus.oANGLE), 0);
    check("midrst_lut_addr", int'(bus.oLUT_ADDR), 0);
    check("midrst_busy", int'(bus.oBUSY), 0);
    check("midrst_update", int'(bus.oUPDATE), 0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    m_angle = 0; m_cnt = 0;
    upd_seen = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.oUPDATE) upd_seen++;
    end
    check("postrst_update_seen", upd_seen, 0);
    check("postrst_angle", int'(bus.oANGLE), 0);
    check("postrst_cos", int'(bus.oCOS), 127);

    // Switch changes mid-frame leave the coefficients alone
    run_frame(1'b0, 1'b0, 7'd20, 8'd0, 0);
    ang0 = bus.oANGLE; s0 = bus.oSIN; c0 = bus.oCOS;
    chg = 0;
    repeat (20) begin
      @(negedge CLK);
      scramble();
      bus.iTHETA_SET = 7'd50;
      if (bus.oANGLE !== ang0 || bus.oSIN !== s0 || bus.oCOS !== c0) chg++;
    end
    check("midframe_coef_changes", chg, 0);
    run_frame(1'b0, 1'b0, 7'd50, 8'd0, 0);
    check("midframe_next_sync_angle", int'(bus.oANGLE), 50);

    // Randomized frames against the model
    for (int i = 0; i < 150; i++) begin
      logic       ra, rd;
      logic [6:0] rth;
      logic [7:0] rrt;
      ra  = 1'($urandom_range(0, 2) != 0);
      rd  = 1'($urandom);
      rth = 7'($urandom_range(0, 127));
      rrt = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      run_frame(ra, rd, rth, rrt, int'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
